// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared cell layout, command opcodes and FSM states for the game board
package game_pkg;

    // Cell word layout
    localparam int CNT_LSB      = 0;
    localparam int CNT_W        = 4;
    localparam int BIT_MINE     = 4;
    localparam int BIT_REVEALED = 5;
    localparam int BIT_FLAGGED  = 6;
    localparam int BIT_RSV      = 7;

    typedef enum logic [1:0] {
        OP_REVEAL      = 2'd0,
        OP_TOGGLE_FLAG = 2'd1,
        OP_SET_MINE    = 2'd2,
        OP_SET_COUNT   = 2'd3
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_CLEAR  = 3'd0,
        ST_IDLE   = 3'd1,
        ST_WB_ACK = 3'd2,
        ST_CMD_RD = 3'd3,
        ST_CMD_WR = 3'd4
    } state_e;

endpackage

// File: rtl/board_ram.sv
// rtl/board_ram.sv - single-port synchronous board storage, registered read
module board_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // One access per cycle: a write, or a read whose data appears next cycle
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/game_board_mem.sv
// rtl/game_board_mem.sv - game board memory with wishbone port and command engine (optional BOARD_STATS_EN)
module game_board_mem
    import game_pkg::*;
#(
    parameter int ROWS_MAX = 16,
    parameter int COLS_MAX = 16,
    parameter int CELL_W   = 8
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    wb_cyc,
    input  logic                                    wb_stb,
    input  logic                                    wb_we,
    input  logic [$clog2(ROWS_MAX*COLS_MAX)-1:0]    wb_adr,
    input  logic [CELL_W-1:0]                       wb_dat_m,
    output logic [CELL_W-1:0]                       wb_dat_s,
    output logic                                    wb_ack,
    input  logic                                    clear_req,
    output logic                                    busy,
    input  logic                                    cmd_valid,
    output logic                                    cmd_ready,
    input  logic [1:0]                              cmd_op,
    input  logic [$clog2(ROWS_MAX)-1:0]             cmd_row,
    input  logic [$clog2(COLS_MAX)-1:0]             cmd_col,
    input  logic [3:0]                              cmd_count
`ifdef BOARD_STATS_EN
    ,
    output logic [$clog2(ROWS_MAX*COLS_MAX):0]      revealed_cnt,
    output logic [$clog2(ROWS_MAX*COLS_MAX):0]      flag_cnt
`endif
);

    localparam int RW    = $clog2(ROWS_MAX);
    localparam int CW    = $clog2(COLS_MAX);
    localparam int AW    = RW + CW;
    localparam int DEPTH = ROWS_MAX * COLS_MAX;

    state_e              state, state_nxt;
    logic [AW-1:0]       clr_addr;
    cmd_op_e             op_q;
    logic [RW-1:0]       row_q;
    logic [CW-1:0]       col_q;
    logic [3:0]          count_q;

    logic                ram_en, ram_we;
    logic [AW-1:0]       ram_addr;
    logic [CELL_W-1:0]   ram_wdata, ram_rdata, new_cell;
    logic                wb_req;

    assign wb_req   = wb_cyc & wb_stb;
    assign busy     = (state == ST_CLEAR);
    // Read data is only presented during the acknowledge cycle
    assign wb_dat_s = wb_ack ? ram_rdata : '0;

    board_ram #(.ADDR_W(AW), .DATA_W(CELL_W)) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_CLEAR;
        else        state <= state_nxt;
    end

    // Wipe address walks the whole board; clear_req restarts it at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                clr_addr <= '0;
        else if (clear_req)        clr_addr <= '0;
        else if (state == ST_CLEAR) clr_addr <= clr_addr + 1'b1;
    end

    // Capture the command when it is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= OP_REVEAL;
            row_q   <= '0;
            col_q   <= '0;
            count_q <= '0;
        end else if (cmd_ready) begin
            op_q    <= cmd_op_e'(cmd_op);
            row_q   <= cmd_row;
            col_q   <= cmd_col;
            count_q <= cmd_count;
        end
    end

    // Read-modify-write result for the latched command
    always_comb begin
        new_cell = ram_rdata;
        case (op_q)
            OP_REVEAL:      if (!ram_rdata[BIT_FLAGGED])  new_cell[BIT_REVEALED] = 1'b1;
            OP_TOGGLE_FLAG: if (!ram_rdata[BIT_REVEALED]) new_cell[BIT_FLAGGED]  = ~ram_rdata[BIT_FLAGGED];
            OP_SET_MINE:    new_cell[BIT_MINE] = 1'b1;
            OP_SET_COUNT:   new_cell[CNT_LSB +: CNT_W] = count_q;
            default:        new_cell = ram_rdata;
        endcase
        new_cell[BIT_RSV] = 1'b0;
    end

    // Next state, RAM control and handshakes; clear_req overrides everything
    always_comb begin
        state_nxt = state;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = clr_addr;
        ram_wdata = '0;
        cmd_ready = 1'b0;
        wb_ack    = 1'b0;
        case (state)
            ST_CLEAR: begin
                ram_en = 1'b1;
                ram_we = 1'b1;
                if (clr_addr == AW'(DEPTH - 1)) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (wb_req) begin
                    ram_en    = 1'b1;
                    ram_we    = wb_we;
                    ram_addr  = wb_adr;
                    ram_wdata = wb_dat_m;
                    ram_wdata[BIT_RSV] = 1'b0;
                    state_nxt = ST_WB_ACK;
                end else if (cmd_valid) begin
                    cmd_ready = 1'b1;
                    state_nxt = ST_CMD_RD;
                end
            end
            ST_WB_ACK: begin
                wb_ack    = 1'b1;
                state_nxt = ST_IDLE;
            end
            ST_CMD_RD: begin
                ram_en    = 1'b1;
                ram_addr  = {row_q, col_q};
                state_nxt = ST_CMD_WR;
            end
            ST_CMD_WR: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = {row_q, col_q};
                ram_wdata = new_cell;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_CLEAR;
        endcase
        if (clear_req) begin
            state_nxt = ST_CLEAR;
            ram_en    = 1'b0;
            ram_we    = 1'b0;
            cmd_ready = 1'b0;
            wb_ack    = 1'b0;
        end
    end

`ifdef BOARD_STATS_EN
    // Count first reveals of non-mine cells and net flag changes made by commands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            revealed_cnt <= '0;
            flag_cnt     <= '0;
        end else if (clear_req) begin
            revealed_cnt <= '0;
            flag_cnt     <= '0;
        end else if (state == ST_CMD_WR) begin
            if (op_q == OP_REVEAL && !ram_rdata[BIT_FLAGGED] &&
                !ram_rdata[BIT_REVEALED] && !ram_rdata[BIT_MINE])
                revealed_cnt <= revealed_cnt + 1'b1;
            if (op_q == OP_TOGGLE_FLAG && !ram_rdata[BIT_REVEALED]) begin
                if (ram_rdata[BIT_FLAGGED]) flag_cnt <= flag_cnt - 1'b1;
                else                        flag_cnt <= flag_cnt + 1'b1;
            end
        end
    end
`endif

endmodule
